alu_operand_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU.
- Accepts an instruction plus its register-file read data, decodes the ALU operation and selects and extends both operands.
- Registers the resulting bundle (ALUConf, Sign, In1, In2) and presents it to the ALU through a valid/ready handshake.
- Decouples register-read timing from ALU timing and gives the multi-cycle controller a single registered point to stall or flush.

---
 rtl/alu_operand_stage_pkg.sv | 95 +++++++++
 rtl/alu_operand_stage_decode.sv | 50 +++++
 rtl/alu_operand_stage.sv | 95 +++++++++
 tb/tb_alu_operand_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared decode constants and types for the ALU operand stage.
package alu_operand_stage_pkg;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLL = 5'd6;
    localparam logic [4:0] ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA = 5'd8;
    localparam logic [4:0] ALU_SLT = 5'd9;

    // opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // lui is executed as "imm << 16" on the ALU
    localparam int LUI_SHIFT = 16;

    typedef enum logic [2:0] {
        IN1_ZERO,
        IN1_RS,
        IN1_SHAMT,
        IN1_RS_LOW5,
        IN1_LUI_SHIFT
    } in1_sel_e;

    typedef enum logic [1:0] {
        IN2_ZERO,
        IN2_RT,
        IN2_IMM
    } in2_sel_e;

    typedef enum logic {
        EXT_ZERO,
        EXT_SIGN
    } ext_e;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_RD,
        DEST_RT
    } dest_sel_e;

    typedef struct packed {
        logic [4:0] conf;
        logic       sign;
        in1_sel_e   in1_sel;
        in2_sel_e   in2_sel;
        ext_e       ext;
        dest_sel_e  dest_sel;
        logic       illegal;
    } dec_t;

    // Undecodable instructions collapse to an all-zero bundle flagged illegal
    localparam dec_t DEC_ILLEGAL = '{ALU_ADD, 1'b0, IN1_ZERO, IN2_ZERO, EXT_ZERO, DEST_NONE, 1'b1};

    function automatic dec_t mk_dec(input logic [4:0] conf, input logic sign,
                                    input in1_sel_e s1, input in2_sel_e s2,
                                    input ext_e ext, input dest_sel_e d);
        mk_dec = '{conf, sign, s1, s2, ext, d, 1'b0};
    endfunction

endpackage

// File: rtl/alu_operand_stage_decode.sv
// Combinational decode of opcode/funct into ALU control and operand selects.
module alu_op_decode
    import alu_operand_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Map opcode/funct to the control bundle; anything unlisted is illegal
    always_comb begin
        dec = DEC_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec = mk_dec(ALU_ADD, 1'b1, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_ADDU: dec = mk_dec(ALU_ADD, 1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SUB:  dec = mk_dec(ALU_SUB, 1'b1, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SUBU: dec = mk_dec(ALU_SUB, 1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_AND:  dec = mk_dec(ALU_AND, 1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_OR:   dec = mk_dec(ALU_OR,  1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_XOR:  dec = mk_dec(ALU_XOR, 1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_NOR:  dec = mk_dec(ALU_NOR, 1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SLT:  dec = mk_dec(ALU_SLT, 1'b1, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SLTU: dec = mk_dec(ALU_SLT, 1'b0, IN1_RS, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SLL:  dec = mk_dec(ALU_SLL, 1'b0, IN1_SHAMT,   IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SRL:  dec = mk_dec(ALU_SRL, 1'b0, IN1_SHAMT,   IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SRA:  dec = mk_dec(ALU_SRA, 1'b0, IN1_SHAMT,   IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SLLV: dec = mk_dec(ALU_SLL, 1'b0, IN1_RS_LOW5, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SRLV: dec = mk_dec(ALU_SRL, 1'b0, IN1_RS_LOW5, IN2_RT, EXT_ZERO, DEST_RD);
                    FN_SRAV: dec = mk_dec(ALU_SRA, 1'b0, IN1_RS_LOW5, IN2_RT, EXT_ZERO, DEST_RD);
                    default: dec = DEC_ILLEGAL;
                endcase
            end
            OP_ADDI:  dec = mk_dec(ALU_ADD, 1'b1, IN1_RS, IN2_IMM, EXT_SIGN, DEST_RT);
            OP_ADDIU: dec = mk_dec(ALU_ADD, 1'b0, IN1_RS, IN2_IMM, EXT_SIGN, DEST_RT);
            OP_SLTI:  dec = mk_dec(ALU_SLT, 1'b1, IN1_RS, IN2_IMM, EXT_SIGN, DEST_RT);
            OP_SLTIU: dec = mk_dec(ALU_SLT, 1'b0, IN1_RS, IN2_IMM, EXT_SIGN, DEST_RT);
            OP_LW:    dec = mk_dec(ALU_ADD, 1'b0, IN1_RS, IN2_IMM, EXT_SIGN, DEST_RT);
            OP_SW:    dec = mk_dec(ALU_ADD, 1'b0, IN1_RS, IN2_IMM, EXT_SIGN, DEST_NONE);
            OP_BEQ:   dec = mk_dec(ALU_SUB, 1'b0, IN1_RS, IN2_RT,  EXT_ZERO, DEST_NONE);
            OP_ANDI:  dec = mk_dec(ALU_AND, 1'b0, IN1_RS, IN2_IMM, EXT_ZERO, DEST_RT);
            OP_ORI:   dec = mk_dec(ALU_OR,  1'b0, IN1_RS, IN2_IMM, EXT_ZERO, DEST_RT);
            OP_XORI:  dec = mk_dec(ALU_XOR, 1'b0, IN1_RS, IN2_IMM, EXT_ZERO, DEST_RT);
            OP_LUI:   dec = mk_dec(ALU_SLL, 1'b0, IN1_LUI_SHIFT, IN2_IMM, EXT_ZERO, DEST_RT);
            default:  dec = DEC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the ALU: decode, operand select/extend,
// and a one-entry valid/ready holding register with flush.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CONF_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CONF_W-1:0] ALUConf,
    output logic              Sign,
    output logic [DATA_W-1:0] In1,
    output logic [DATA_W-1:0] In2,
    output logic [4:0]        dest_reg,
    output logic              illegal
);

    dec_t              dec;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] in1_d;
    logic [DATA_W-1:0] in2_d;
    logic [4:0]        dest_d;
    logic              load;

    // rs register number is not needed: the register file already supplied rs_data
    logic unused_rs_field;
    assign unused_rs_field = ^instr[25:21];

    alu_op_decode u_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Operand and destination muxes driven by the decoded selects
    always_comb begin
        imm_ext = (dec.ext == EXT_SIGN) ? {{(DATA_W-16){instr[15]}}, instr[15:0]}
                                        : {{(DATA_W-16){1'b0}}, instr[15:0]};
        case (dec.in1_sel)
            IN1_RS:        in1_d = rs_data;
            IN1_SHAMT:     in1_d = DATA_W'(instr[10:6]);
            IN1_RS_LOW5:   in1_d = DATA_W'(rs_data[4:0]);
            IN1_LUI_SHIFT: in1_d = DATA_W'(LUI_SHIFT);
            default:       in1_d = '0;
        endcase
        case (dec.in2_sel)
            IN2_RT:  in2_d = rt_data;
            IN2_IMM: in2_d = imm_ext;
            default: in2_d = '0;
        endcase
        case (dec.dest_sel)
            DEST_RD: dest_d = instr[15:11];
            DEST_RT: dest_d = instr[20:16];
            default: dest_d = 5'd0;
        endcase
    end

    // Holding register: flush wins, then load, then drain; data holds otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            ALUConf   <= '0;
            Sign      <= 1'b0;
            In1       <= '0;
            In2       <= '0;
            dest_reg  <= 5'd0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            ALUConf   <= CONF_W'(dec.conf);
            Sign      <= dec.sign;
            In1       <= in1_d;
            In2       <= in2_d;
            dest_reg  <= dest_d;
            illegal   <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a behavioural reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  ALUConf;
    logic        Sign;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [4:0]  dest_reg;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    alu_operand_stage #(.DATA_W(32), .CONF_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUConf   (ALUConf),
        .Sign      (Sign),
        .In1       (In1),
        .In2       (In2),
        .dest_reg  (dest_reg),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  conf;
        logic        sign;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  dest;
        logic        ill;
    } bundle_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic [4:0] conf, input logic sign,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] d);
        mk = '{conf, sign, a, b, d, 1'b0};
    endfunction

    // Reference: what the ALU must receive for a given instruction and operands
    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] rs,
                                             input logic [31:0] rt);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        logic [31:0] sh;
        logic [4:0]  rd;
        logic [4:0]  rtn;
        bundle_t     b;
        op  = ins[31:26];
        fn  = ins[5:0];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0000, ins[15:0]};
        sh  = {27'd0, ins[10:6]};
        rd  = ins[15:11];
        rtn = ins[20:16];
        b   = '{5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1};
        if (op == 6'h00) begin
            case (fn)
                6'h20: b = mk(0, 1, rs, rt, rd);
                6'h21: b = mk(0, 0, rs, rt, rd);
                6'h22: b = mk(1, 1, rs, rt, rd);
                6'h23: b = mk(1, 0, rs, rt, rd);
                6'h24: b = mk(2, 0, rs, rt, rd);
                6'h25: b = mk(3, 0, rs, rt, rd);
                6'h26: b = mk(4, 0, rs, rt, rd);
                6'h27: b = mk(5, 0, rs, rt, rd);
                6'h2A: b = mk(9, 1, rs, rt, rd);
                6'h2B: b = mk(9, 0, rs, rt, rd);
                6'h00: b = mk(6, 0, sh, rt, rd);
                6'h02: b = mk(7, 0, sh, rt, rd);
                6'h03: b = mk(8, 0, sh, rt, rd);
                6'h04: b = mk(6, 0, rs % 32, rt, rd);
                6'h06: b = mk(7, 0, rs % 32, rt, rd);
                6'h07: b = mk(8, 0, rs % 32, rt, rd);
                default: ;
            endcase
        end else begin
            case (op)
                6'h08: b = mk(0, 1, rs, sx, rtn);
                6'h09: b = mk(0, 0, rs, sx, rtn);
                6'h0A: b = mk(9, 1, rs, sx, rtn);
                6'h0B: b = mk(9, 0, rs, sx, rtn);
                6'h23: b = mk(0, 0, rs, sx, rtn);
                6'h2B: b = mk(0, 0, rs, sx, 5'd0);
                6'h04: b = mk(1, 0, rs, rt, 5'd0);
                6'h0C: b = mk(2, 0, rs, zx, rtn);
                6'h0D: b = mk(3, 0, rs, zx, rtn);
                6'h0E: b = mk(4, 0, rs, zx, rtn);
                6'h0F: b = mk(6, 0, 32'd16, zx, rtn);
                default: ;
            endcase
        end
        return b;
    endfunction

    logic    m_valid = 1'b0;
    bundle_t m_b = '0;

    // Model of the one-entry buffer: what the ALU side should see after each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_b     <= '0;
        end else begin
            logic accept;
            accept = in_valid && (!m_valid || out_ready);
            if (flush)
                m_valid <= 1'b0;
            else if (accept) begin
                m_valid <= 1'b1;
                m_b     <= model_decode(instr, rs_data, rt_data);
            end else if (m_valid && out_ready)
                m_valid <= 1'b0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        if (m_valid || !reset) begin
            chk("ALUConf", {27'd0, ALUConf}, {27'd0, m_b.conf});
            chk("Sign", {31'd0, Sign}, {31'd0, m_b.sign});
            chk("In1", In1, m_b.in1);
            chk("In2", In2, m_b.in2);
            chk("dest_reg", {27'd0, dest_reg}, {27'd0, m_b.dest});
            chk("illegal", {31'd0, illegal}, {31'd0, m_b.ill});
        end
    end

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic ordy, input logic fl);
        in_valid  = iv;
        instr     = ins;
        rs_data   = rs;
        rt_data   = rt;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_b(input string name, input logic v, input logic [4:0] conf,
                            input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, input logic il);
        chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({name, ".conf"}, {27'd0, ALUConf}, {27'd0, conf});
        chk({name, ".sign"}, {31'd0, Sign}, {31'd0, s});
        chk({name, ".in1"}, In1, a);
        chk({name, ".in2"}, In2, b);
        chk({name, ".dest"}, {27'd0, dest_reg}, {27'd0, d});
        chk({name, ".illegal"}, {31'd0, illegal}, {31'd0, il});
    endtask

    localparam logic [31:0] I_ADD  = 32'h00221820;  // add  $3,$1,$2
    localparam logic [31:0] I_ANDI = 32'h30248001;  // andi $4,$1,0x8001
    localparam logic [31:0] I_SLTI = 32'h28258001;  // slti $5,$1,0x8001
    localparam logic [31:0] I_LUI  = 32'h3C061234;  // lui  $6,0x1234
    localparam logic [31:0] I_SRA  = 32'h000238C3;  // sra  $7,$2,3
    localparam logic [31:0] I_BAD  = 32'hFC221820;  // opcode 0x3F

    logic [31:0] extra [8];

    initial begin
        extra = '{32'h00224007,   // srav $8,$2,$1
                  32'hAC22FFFC,   // sw   $2,-4($1)
                  32'h10220010,   // beq  $1,$2,0x10
                  32'h0022482B,   // sltu $9,$1,$2
                  32'h00225027,   // nor  $10,$1,$2
                  32'h0022503F,   // R-type, bad funct
                  32'h8C2BFFF0,   // lw   $11,-16($1)
                  32'h3823F00F};  // xori $3,$1,0xF00F

        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        expect_b("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;

        drive(1, I_ADD, 32'd5, 32'hFFFFFFFD, 1, 0);
        tick();
        expect_b("add", 1, 0, 1, 32'd5, 32'hFFFFFFFD, 3, 0);

        drive(1, I_ANDI, 32'h11, 32'h0, 1, 0);
        tick();
        expect_b("andi", 1, 2, 0, 32'h11, 32'h00008001, 4, 0);

        drive(1, I_SLTI, 32'h22, 32'h0, 1, 0);
        tick();
        expect_b("slti", 1, 9, 1, 32'h22, 32'hFFFF8001, 5, 0);

        drive(1, I_LUI, 32'h33, 32'h0, 1, 0);
        tick();
        expect_b("lui", 1, 6, 0, 32'd16, 32'h00001234, 6, 0);

        drive(1, I_SRA, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        tick();
        expect_b("sra", 1, 8, 0, 32'd3, 32'h80000000, 7, 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, extra[i], 32'h12345678 + i, 32'h9ABCDEF0 ^ i, 1, 0);
            tick();
        end

        drive(1, I_BAD, 32'd7, 32'd8, 1, 0);
        tick();
        expect_b("illegal", 1, 0, 0, 0, 0, 0, 1);

        // back-pressure: three stalled cycles, then the queued bundle moves in
        drive(1, I_ADD, 32'hA1, 32'hB1, 1, 0);
        tick();
        drive(1, I_ADD, 32'hA2, 32'hB2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall.valid", {31'd0, out_valid}, 32'd1);
            chk("stall.in1", In1, 32'hA1);
            chk("stall.in2", In2, 32'hB1);
        end
        out_ready = 1'b1;
        tick();
        chk("unstall.valid", {31'd0, out_valid}, 32'd1);
        chk("unstall.in1", In1, 32'hA2);
        drive(1, I_ADD, 32'hA3, 32'hB3, 1, 0);
        tick();
        chk("next.in1", In1, 32'hA3);
        drive(0, I_ADD, 32'hA9, 32'hB9, 1, 0);
        tick();
        chk("drain.valid", {31'd0, out_valid}, 32'd0);
        chk("drain.hold_in1", In1, 32'hA3);

        // flush together with a load
        drive(1, I_ADD, 32'hA4, 32'hB4, 1, 0);
        tick();
        chk("preflush.valid", {31'd0, out_valid}, 32'd1);
        drive(1, I_ADD, 32'hA5, 32'hB5, 1, 1);
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("flush.valid", {31'd0, out_valid}, 32'd0);

        // flush while stalled
        drive(1, I_ADD, 32'hA6, 32'hB6, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("flush_stall.valid", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-stream
        drive(1, I_SLTI, 32'hA7, 32'hB7, 1, 0);
        tick();
        chk("prereset.valid", {31'd0, out_valid}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        expect_b("async_reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive(1, I_LUI, 32'hA8, 32'hB8, 1, 0);
        tick();
        expect_b("post_reset_lui", 1, 6, 0, 32'd16, 32'h00001234, 6, 0);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
